// File: rtl/lzc_feeder_if.sv
// rtl/lzc_feeder_if.sv - operand-in / word-out handshake bundle between a producer and lzc_feeder
interface lzc_feeder_if #(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
);
  localparam int CW = $clog2(WORD) + 1;

  logic                  in_valid;
  logic [WIDTH*WORD-1:0] in_data;
  logic                  in_mode;
  logic                  in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_mode;
  logic                  out_ready;
  logic                  done_in;
  logic                  busy;
  logic [CW-1:0]         words_sent;

  modport master (
    output in_valid, in_data, in_mode, out_ready, done_in,
    input  in_ready, out_valid, out_data, out_mode, busy, words_sent
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready, done_in,
    output in_ready, out_valid, out_data, out_mode, busy, words_sent
  );
endinterface

// File: rtl/lzc_feeder.sv
// rtl/lzc_feeder.sv - buffers operands and serialises them MSB word first into a leading-zero counter
// LZC_FEEDER_SKIDBUF_EN selects a 2-entry operand FIFO instead of a single holding register.
module lzc_feeder #(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  lzc_feeder_if.slave feed
);
  localparam int OW = WIDTH * WORD;
  localparam int CW = $clog2(WORD) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [OW-1:0] shreg;
  logic          mode_q;
  logic [CW-1:0] count;
  logic          out_valid_q;
  logic          busy_q;
  logic [CW-1:0] words_sent_q;

  logic          head_valid;
  logic [OW-1:0] head_data;
  logic          head_mode;
  logic          push;
  logic          pop;

  assign push = feed.in_valid && feed.in_ready;
  assign pop  = (state == IDLE) && head_valid;

`ifdef LZC_FEEDER_SKIDBUF_EN
  logic [1:0]    occ;
  logic [OW-1:0] data0;
  logic [OW-1:0] data1;
  logic          mode0;
  logic          mode1;

  // Shifting FIFO: slot 0 is always the head, so a pop just moves slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ   <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      mode0 <= 1'b0;
      mode1 <= 1'b0;
    end else begin
      if (pop) begin
        data0 <= data1;
        mode0 <= mode1;
      end
      if (push) begin
        if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
          data0 <= feed.in_data;
          mode0 <= feed.in_mode;
        end else begin
          data1 <= feed.in_data;
          mode1 <= feed.in_mode;
        end
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign feed.in_ready = (occ < 2'd2);
  assign head_valid    = (occ != 2'd0);
  assign head_data     = data0;
  assign head_mode     = mode0;
`else
  logic          full;
  logic [OW-1:0] data0;
  logic          mode0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      data0 <= '0;
      mode0 <= 1'b0;
    end else begin
      if (push) begin
        data0 <= feed.in_data;
        mode0 <= feed.in_mode;
      end
      full <= (full && !pop) || push;
    end
  end

  assign feed.in_ready = !full;
  assign head_valid    = full;
  assign head_data     = data0;
  assign head_mode     = mode0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      mode_q       <= 1'b0;
      count        <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (head_valid) begin
            shreg       <= head_data;
            mode_q      <= head_mode;
            count       <= '0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          // An early result in turbo mode beats a word handshake in the same cycle.
          if (feed.done_in && mode_q) begin
            words_sent_q <= count;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end else if (feed.out_ready) begin
            count <= count + CW'(1);
            if (count == LAST) begin
              out_valid_q <= 1'b0;
              state       <= WAIT_DONE;
            end else begin
              shreg <= shreg << WIDTH;
            end
          end
        end
        WAIT_DONE: begin
          if (feed.done_in) begin
            words_sent_q <= count;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign feed.out_valid  = out_valid_q;
  assign feed.out_data   = shreg[OW-1 -: WIDTH];
  assign feed.out_mode   = mode_q;
  assign feed.busy       = busy_q;
  assign feed.words_sent = words_sent_q;
endmodule

// File: tb/tb_lzc_feeder.sv
// tb/tb_lzc_feeder.sv - directed and randomized check of lzc_feeder against a queue-based operand model
module tb_lzc_feeder;
  localparam int WIDTH = 8;
  localparam int WORD  = 4;
  localparam int OW    = WIDTH * WORD;
`ifdef LZC_FEEDER_SKIDBUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [OW-1:0] data;
    logic          mode;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lzc_feeder_if #(.WIDTH(WIDTH), .WORD(WORD)) feed ();
  lzc_feeder #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .feed (feed)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending operands, words still owed for the operand in flight, and its phase.
  op_t              bufq[$];
  logic [WIDTH-1:0] words[$];
  logic             cur_mode;
  int               sent;
  int               phase;
  int               ws;
  bit               last_push;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bufq.delete();
    words.delete();
    cur_mode  = 1'b0;
    sent      = 0;
    phase     = 0;
    ws        = 0;
    last_push = 1'b0;
  endtask

  task automatic model_step();
    bit  push;
    op_t h;
    op_t n;
    push      = feed.in_valid && (bufq.size() < DEPTH);
    last_push = push;
    case (phase)
      0: if (bufq.size() > 0) begin
        h = bufq.pop_front();
        words.delete();
        for (int w = 0; w < WORD; w++) words.push_back(h.data[(WORD-1-w)*WIDTH +: WIDTH]);
        cur_mode = h.mode;
        sent     = 0;
        phase    = 1;
      end
      1: if (feed.done_in && cur_mode) begin
        ws    = sent;
        phase = 0;
        words.delete();
      end else if (feed.out_ready) begin
        words.delete(0);
        sent++;
        if (words.size() == 0) phase = 2;
      end
      2: if (feed.done_in) begin
        ws    = sent;
        phase = 0;
      end
      default: ;
    endcase
    if (push) begin
      n.data = feed.in_data;
      n.mode = feed.in_mode;
      bufq.push_back(n);
    end
  endtask

  task automatic compare();
    check("in_ready", 64'(feed.in_ready), 64'(bufq.size() < DEPTH));
    check("out_valid", 64'(feed.out_valid), 64'(phase == 1));
    check("busy", 64'(feed.busy), 64'(phase != 0));
    check("words_sent", 64'(feed.words_sent), 64'(ws));
    if (phase == 1) begin
      check("out_data", 64'(feed.out_data), 64'(words[0]));
      check("out_mode", 64'(feed.out_mode), 64'(cur_mode));
    end
  endtask

  task automatic step(input logic v, input logic [OW-1:0] d, input logic m,
                      input logic ordy, input logic done);
    feed.in_valid  = v;
    feed.in_data   = d;
    feed.in_mode   = m;
    feed.out_ready = ordy;
    feed.done_in   = done;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic offer(input logic [OW-1:0] d, input logic m, input logic ordy, output int tries);
    tries = 0;
    do begin
      step(1'b1, d, m, ordy, 1'b0);
      tries++;
    end while (!last_push && tries < 10);
    check("offer_accepted", 64'(last_push), 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((phase != 0 || bufq.size() != 0) && guard < 200) begin
      step(1'b0, '0, 1'b0, 1'b1, logic'(phase == 2));
      guard++;
    end
    check("drain_bound", 64'(guard < 200), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            tries;
    int            guard;
    logic          v;
    logic          m;
    logic          ordy;
    logic          done;
    logic [OW-1:0] d;

    feed.in_valid  = 1'b0;
    feed.in_data   = '0;
    feed.in_mode   = 1'b0;
    feed.out_ready = 1'b0;
    feed.done_in   = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(feed.out_valid), 64'd0);
    check("rst_out_data", 64'(feed.out_data), 64'd0);
    check("rst_out_mode", 64'(feed.out_mode), 64'd0);
    check("rst_busy", 64'(feed.busy), 64'd0);
    check("rst_words_sent", 64'(feed.words_sent), 64'd0);
    rst_n = 1'b1;
    compare();

    // Normal mode, four words back to back
    step(1'b1, 32'h000F_8001, 1'b0, 1'b1, 1'b0);
    check("norm_latency", 64'(feed.out_valid), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("norm_w0", 64'(feed.out_data), 64'h00);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("norm_w1", 64'(feed.out_data), 64'h0F);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("norm_w2", 64'(feed.out_data), 64'h80);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("norm_w3", 64'(feed.out_data), 64'h01);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("norm_wait_valid", 64'(feed.out_valid), 64'd0);
    check("norm_wait_busy", 64'(feed.busy), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("norm_words_sent", 64'(feed.words_sent), 64'd4);
    check("norm_idle_busy", 64'(feed.busy), 64'd0);

    // Turbo early stop after the 0xF0 word
    step(1'b1, 32'h00F0_0000, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("turbo_wF0", 64'(feed.out_data), 64'hF0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("turbo_words_sent", 64'(feed.words_sent), 64'd2);
    check("turbo_busy", 64'(feed.busy), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Backpressure on word 1
    step(1'b1, 32'h000F_8001, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("bp_hold_data", 64'(feed.out_data), 64'h0F);
      check("bp_hold_valid", 64'(feed.out_valid), 64'd1);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("bp_w2", 64'(feed.out_data), 64'h80);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("bp_w3", 64'(feed.out_data), 64'h01);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("bp_words_sent", 64'(feed.words_sent), 64'd4);

    // done_in and out_ready together at index 1 of a turbo operand
    step(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("coll_words_sent", 64'(feed.words_sent), 64'd1);
    check("coll_out_valid", 64'(feed.out_valid), 64'd0);

    // Back-to-back operands
    offer(32'h0102_0304, 1'b0, 1'b0, tries);
    offer(32'h8040_2010, 1'b0, 1'b0, tries);
    check("b2b_tries", 64'(tries), 64'((DEPTH == 2) ? 1 : 2));
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("b2b_full_ready", 64'(feed.in_ready), 64'd0);
    guard = 0;
    while (phase != 2 && guard < 20) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    check("b2b_wait_bound", 64'(guard < 20), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("b2b_gap_valid", 64'(feed.out_valid), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("b2b_next_valid", 64'(feed.out_valid), 64'd1);
    check("b2b_next_word", 64'(feed.out_data), 64'h80);
    drain();

    // Reset at word 2 with an operand buffered
    offer(32'h1122_3344, 1'b0, 1'b0, tries);
    offer(32'h5566_7788, 1'b1, 1'b0, tries);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("rstmid_index", 64'(feed.out_data), 64'h33);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(feed.out_valid), 64'd0);
    check("rstmid_out_data", 64'(feed.out_data), 64'd0);
    check("rstmid_out_mode", 64'(feed.out_mode), 64'd0);
    check("rstmid_busy", 64'(feed.busy), 64'd0);
    check("rstmid_words_sent", 64'(feed.words_sent), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 99) < 40);
      m = 1'(($urandom_range(0, 1)));
      for (int w = 0; w < WORD; w++)
        d[w*WIDTH +: WIDTH] = ($urandom_range(0, 99) < 35) ? '0 : WIDTH'($urandom_range(1, 255));
      ordy = ($urandom_range(0, 99) < 70);
      if (phase == 2)
        done = ($urandom_range(0, 99) < 50);
      else if (phase == 1 && cur_mode)
        done = (sent >= 1) && ($urandom_range(0, 99) < 20);
      else
        done = ($urandom_range(0, 99) < 5);
      step(v, d, m, ordy, done);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
